// File: rtl/draw_menu_char.sv
// draw_menu_char: overlays a 16x16 text box of 8x16-pixel cells onto the
// VGA timing stream. Issues char_xy to the char ROM, forms the font ROM
// address from the returned code and the registered glyph line, then paints
// the glyph row (with an optional highlight bar on one text row). All timing
// leaves exactly 3 clocks after it enters.
module draw_menu_char #(
  parameter logic [10:0] XPOS       = 11'd256,
  parameter logic [10:0] YPOS       = 11'd176,
  parameter logic [11:0] LETTER_RGB = 12'hFFF,
  parameter logic [11:0] HL_RGB     = 12'h00F
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [10:0] i_hcount,
  input  logic [10:0] i_vcount,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_hblnk,
  input  logic        i_vblnk,
  input  logic [11:0] i_rgb,
  input  logic        i_sel_en,
  input  logic [3:0]  i_sel_row,
  input  logic [7:0]  i_char_code,
  input  logic [7:0]  i_char_pixels,
  output logic [7:0]  o_char_xy,
  output logic [3:0]  o_char_line,
  output logic [11:0] o_font_addr,
  output logic [10:0] o_hcount,
  output logic [10:0] o_vcount,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_hblnk,
  output logic        o_vblnk,
  output logic [11:0] o_rgb
);

  // Box-relative coordinates; positions left of / above the box wrap high
  // and therefore fail the unsigned range test.
  logic [10:0] w_xrel;
  logic [10:0] w_yrel;
  logic        w_in_box;

  assign w_xrel   = i_hcount - XPOS;
  assign w_yrel   = i_vcount - YPOS;
  assign w_in_box = (w_xrel < 11'd128) && (w_yrel < 11'd256);
  assign o_char_xy = w_in_box ? {w_yrel[7:4], w_xrel[6:3]} : 8'h00;

  // Stage 1: glyph line for the font ROM plus sideband aligned with char_code.
  logic [3:0]  r_char_line;
  logic        r_in_box_d1, r_sel_d1;
  logic [2:0]  r_xsub_d1;
  logic [10:0] r_hcount_d1, r_vcount_d1;
  logic        r_hsync_d1, r_vsync_d1, r_hblnk_d1, r_vblnk_d1;
  logic [11:0] r_rgb_d1;

  // Stage 1 register: sample inputs, compute line and selected-row match.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_char_line <= '0;
      r_in_box_d1 <= 1'b0;
      r_sel_d1    <= 1'b0;
      r_xsub_d1   <= '0;
      r_hcount_d1 <= '0;
      r_vcount_d1 <= '0;
      r_hsync_d1  <= 1'b0;
      r_vsync_d1  <= 1'b0;
      r_hblnk_d1  <= 1'b0;
      r_vblnk_d1  <= 1'b0;
      r_rgb_d1    <= '0;
    end else begin
      r_char_line <= w_yrel[3:0];
      r_in_box_d1 <= w_in_box;
      r_sel_d1    <= i_sel_en && (w_yrel[7:4] == i_sel_row);
      r_xsub_d1   <= w_xrel[2:0];
      r_hcount_d1 <= i_hcount;
      r_vcount_d1 <= i_vcount;
      r_hsync_d1  <= i_hsync;
      r_vsync_d1  <= i_vsync;
      r_hblnk_d1  <= i_hblnk;
      r_vblnk_d1  <= i_vblnk;
      r_rgb_d1    <= i_rgb;
    end
  end

  assign o_char_line = r_char_line;
  assign o_font_addr = {i_char_code, r_char_line};

  // Stage 2: sideband aligned with the font row coming back from the ROM.
  logic        r_in_box_d2, r_sel_d2;
  logic [2:0]  r_xsub_d2;
  logic [10:0] r_hcount_d2, r_vcount_d2;
  logic        r_hsync_d2, r_vsync_d2, r_hblnk_d2, r_vblnk_d2;
  logic [11:0] r_rgb_d2;

  // Stage 2 register: shift the sideband one more clock.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_in_box_d2 <= 1'b0;
      r_sel_d2    <= 1'b0;
      r_xsub_d2   <= '0;
      r_hcount_d2 <= '0;
      r_vcount_d2 <= '0;
      r_hsync_d2  <= 1'b0;
      r_vsync_d2  <= 1'b0;
      r_hblnk_d2  <= 1'b0;
      r_vblnk_d2  <= 1'b0;
      r_rgb_d2    <= '0;
    end else begin
      r_in_box_d2 <= r_in_box_d1;
      r_sel_d2    <= r_sel_d1;
      r_xsub_d2   <= r_xsub_d1;
      r_hcount_d2 <= r_hcount_d1;
      r_vcount_d2 <= r_vcount_d1;
      r_hsync_d2  <= r_hsync_d1;
      r_vsync_d2  <= r_vsync_d1;
      r_hblnk_d2  <= r_hblnk_d1;
      r_vblnk_d2  <= r_vblnk_d1;
      r_rgb_d2    <= r_rgb_d1;
    end
  end

  logic        w_pix_bit;
  logic [11:0] w_rgb_next;

  assign w_pix_bit = i_char_pixels[3'd7 - r_xsub_d2];

  // Composite: blanking wins, then glyph, then highlight bar, then background.
  always_comb begin
    w_rgb_next = r_rgb_d2;
    if (r_hblnk_d2 || r_vblnk_d2)
      w_rgb_next = 12'h000;
    else if (r_in_box_d2 && w_pix_bit)
      w_rgb_next = LETTER_RGB;
    else if (r_in_box_d2 && r_sel_d2)
      w_rgb_next = HL_RGB;
  end

  // Stage 3 register: outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_hcount <= '0;
      o_vcount <= '0;
      o_hsync  <= 1'b0;
      o_vsync  <= 1'b0;
      o_hblnk  <= 1'b0;
      o_vblnk  <= 1'b0;
      o_rgb    <= '0;
    end else begin
      o_hcount <= r_hcount_d2;
      o_vcount <= r_vcount_d2;
      o_hsync  <= r_hsync_d2;
      o_vsync  <= r_vsync_d2;
      o_hblnk  <= r_hblnk_d2;
      o_vblnk  <= r_vblnk_d2;
      o_rgb    <= w_rgb_next;
    end
  end

endmodule
